// File: rtl/xor_serial_sched_if.sv
// Handshake bundle between operand producers / result consumer and xor_serial_sched.
// master = producer/consumer side, slave = scheduler side.
interface xor_serial_sched_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ready;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready
    );
endinterface

// File: rtl/xor_serial_sched.sv
// Round-robin scheduler sharing one 1-bit XOR cell between two requesters;
// operands are processed LSB first and the assembled result is returned with the owner ID.
module xor_serial_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    xor_serial_sched_if.slave    bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;

    logic             pick_c;
    logic             accept_c;
    logic             xor_bit_c;

    // Winner selection: a lone valid requester wins, otherwise the one not granted last.
    always_comb begin
        pick_c = ~last_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            pick_c = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            pick_c = 1'b1;
        end
    end

    assign bus.req0_ready = (state_q == IDLE) && !pick_c;
    assign bus.req1_ready = (state_q == IDLE) &&  pick_c;
    assign accept_c       = (state_q == IDLE) &&
                            (pick_c ? bus.req1_valid : bus.req0_valid);

    // The shared XOR cell; its output enters the result register at the MSB.
    assign xor_bit_c = a_q[0] ^ b_q[0];
    assign r_d       = {xor_bit_c, r_q[WIDTH-1:1]};

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q     <= pick_c ? bus.req1_a : bus.req0_a;
                        b_q     <= pick_c ? bus.req1_b : bus.req0_b;
                        owner_q <= pick_c;
                        last_q  <= pick_c;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    r_q <= r_d;
                    if (cnt_q == CNT_LAST) begin
                        res_data_q  <= r_d;
                        res_id_q    <= owner_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xor_serial_sched.sv
// Scoreboard bench for xor_serial_sched: WIDTH=8 main instance plus a WIDTH=2 instance.
module tb_xor_serial_sched;
    typedef struct {
        logic [31:0] data;
        logic        id;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   acc_q[$];
    int   acc2_q[$];

    bit   prev_v8;
    bit   prev_v2;
    bit   contention;
    bit   have_rise;
    int   last_rise;

    xor_serial_sched_if #(.WIDTH(8)) bus8 ();
    xor_serial_sched_if #(.WIDTH(2)) bus2 ();

    xor_serial_sched #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    xor_serial_sched #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic void fail_now(input string nm, input int val);
        checks++;
        errors++;
        $display("FAIL %s: got %0d (cycle %0d)", nm, val, cyc);
    endfunction

    // Monitor for the 8-bit instance: accept tracking, latency, spacing and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            prev_v8 = 1'b0;
        end else begin
            exp_t e;
            int   a;
            chk("one_ready8", 32'(bus8.req0_ready & bus8.req1_ready), 32'd0);
            if ((bus8.req0_valid && bus8.req0_ready) || (bus8.req1_valid && bus8.req1_ready))
                acc_q.push_back(cyc);
            if (bus8.res_valid && !prev_v8) begin
                if (acc_q.size() == 0) begin
                    fail_now("rise_without_accept8", cyc);
                end else begin
                    a = acc_q.pop_front();
                    chk("latency8", 32'(cyc - a), 32'd9);
                end
                if (contention && have_rise) chk("spacing8", 32'(cyc - last_rise), 32'd10);
                last_rise = cyc;
                have_rise = 1'b1;
            end
            prev_v8 = bus8.res_valid;
            if (bus8.res_valid && bus8.res_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result8", int'(bus8.res_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data8", 32'(bus8.res_data), e.data);
                    chk("res_id8", 32'(bus8.res_id), 32'(e.id));
                end
            end
        end
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            acc2_q.delete();
            prev_v2 = 1'b0;
        end else begin
            exp_t e;
            int   a;
            if ((bus2.req0_valid && bus2.req0_ready) || (bus2.req1_valid && bus2.req1_ready))
                acc2_q.push_back(cyc);
            if (bus2.res_valid && !prev_v2) begin
                if (acc2_q.size() == 0) begin
                    fail_now("rise_without_accept2", cyc);
                end else begin
                    a = acc2_q.pop_front();
                    chk("latency2", 32'(cyc - a), 32'd3);
                end
            end
            prev_v2 = bus2.res_valid;
            if (bus2.res_valid && bus2.res_ready) begin
                if (exp2_q.size() == 0) begin
                    fail_now("unexpected_result2", int'(bus2.res_data));
                end else begin
                    e = exp2_q.pop_front();
                    chk("res_data2", 32'(bus2.res_data), e.data);
                    chk("res_id2", 32'(bus2.res_id), 32'(e.id));
                end
            end
        end
    end

    task automatic push8(input logic [31:0] d, input logic id);
        exp_t e;
        e.data = d;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called just after a posedge; returns just after the accept edge with valid dropped.
    task automatic send8(input bit id, input logic [7:0] a, input logic [7:0] b);
        bit got;
        got = 1'b0;
        if (id) begin
            bus8.req1_valid = 1'b1; bus8.req1_a = a; bus8.req1_b = b;
        end else begin
            bus8.req0_valid = 1'b1; bus8.req0_a = a; bus8.req0_b = b;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? bus8.req1_ready : bus8.req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("accept_timeout8", int'(id));
        @(posedge clk); #1;
        bus8.req0_valid = 1'b0; bus8.req1_valid = 1'b0;
        bus8.req0_a = 8'hFF; bus8.req0_b = 8'hFF;
        bus8.req1_a = 8'hFF; bus8.req1_b = 8'hFF;
    endtask

    // Both requesters valid until n accepts have been seen.
    task automatic contend8(input int n);
        int seen;
        seen = 0;
        bus8.req0_valid = 1'b1; bus8.req0_a = 8'hFF; bus8.req0_b = 8'h00;
        bus8.req1_valid = 1'b1; bus8.req1_a = 8'h3C; bus8.req1_b = 8'h3C;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (bus8.req0_ready || bus8.req1_ready) begin
                seen++;
                @(posedge clk); #1;
            end
        end
        if (seen < n) fail_now("contend_timeout8", seen);
        bus8.req0_valid = 1'b0;
        bus8.req1_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            fail_now("drain_timeout", exp_q.size() + exp2_q.size());
            exp_q.delete();
            exp2_q.delete();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e2;
        bit   got;
        cyc = 0; checks = 0; errors = 0;
        contention = 1'b0; have_rise = 1'b0; last_rise = 0;
        rst = 1'b1;
        bus8.req0_valid = 1'b0; bus8.req0_a = '0; bus8.req0_b = '0;
        bus8.req1_valid = 1'b0; bus8.req1_a = '0; bus8.req1_b = '0;
        bus8.res_ready  = 1'b0;
        bus2.req0_valid = 1'b0; bus2.req0_a = '0; bus2.req0_b = '0;
        bus2.req1_valid = 1'b0; bus2.req1_a = '0; bus2.req1_b = '0;
        bus2.res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_res_valid", 32'(bus8.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus8.res_data), 32'd0);
        chk("rst_res_id", 32'(bus8.res_id), 32'd0);
        chk("rst_req0_ready", 32'(bus8.req0_ready), 32'd1);
        chk("rst_req1_ready", 32'(bus8.req1_ready), 32'd0);
        chk("rst_res_valid2", 32'(bus2.res_valid), 32'd0);

        // Single request
        @(posedge clk); #1;
        bus8.res_ready = 1'b1;
        push8(32'hAA, 1'b0);
        send8(1'b0, 8'hA5, 8'h0F);
        drain(50);
        @(negedge clk);
        chk("pulse_low", 32'(bus8.res_valid), 32'd0);

        // Contention, strict alternation from requester 0
        do_reset();
        contention = 1'b1;
        have_rise  = 1'b0;
        push8(32'hFF, 1'b0);
        push8(32'h00, 1'b1);
        push8(32'hFF, 1'b0);
        push8(32'h00, 1'b1);
        contend8(4);
        drain(100);
        contention = 1'b0;

        // Backpressure
        @(posedge clk); #1;
        bus8.res_ready = 1'b0;
        push8(32'h26, 1'b1);
        send8(1'b1, 8'h12, 8'h34);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus8.res_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("bp_valid_timeout", 0);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            chk("bp_hold_valid", 32'(bus8.res_valid), 32'd1);
            chk("bp_hold_data", 32'(bus8.res_data), 32'h26);
            chk("bp_ready0", 32'(bus8.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus8.req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus8.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_hold6_valid", 32'(bus8.res_valid), 32'd1);
        chk("bp_hold6_data", 32'(bus8.res_data), 32'h26);
        @(negedge clk);
        chk("bp_released", 32'(bus8.res_valid), 32'd0);
        chk("bp_idle_ready0", 32'(bus8.req0_ready), 32'd1);
        chk("bp_data_kept", 32'(bus8.res_data), 32'h26);
        drain(10);

        // Operand release after accept
        @(posedge clk); #1;
        push8(32'h69, 1'b0);
        send8(1'b0, 8'h5A, 8'h33);
        drain(50);

        // Reset during RUN bit 3, then requester 0 must win contention
        @(posedge clk); #1;
        send8(1'b0, 8'h11, 8'h22);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("no_result_after_rst", 32'(bus8.res_valid), 32'd0);
        end
        @(posedge clk); #1;
        push8(32'hFF, 1'b0);
        push8(32'h00, 1'b1);
        contend8(2);
        drain(100);

        // WIDTH=2 instance
        @(posedge clk); #1;
        e2.data = 32'h2;
        e2.id   = 1'b0;
        exp2_q.push_back(e2);
        bus2.req0_valid = 1'b1; bus2.req0_a = 2'b01; bus2.req0_b = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("accept_timeout2", 0);
        @(posedge clk); #1;
        bus2.req0_valid = 1'b0; bus2.req0_a = 2'b11; bus2.req0_b = 2'b11;
        drain(20);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
